block_memory_responder: RTL



---
 rtl/mem_if_pkg.sv | 15 +
 rtl/block_store.sv | 31 +++
 rtl/block_memory_responder.sv | 114 +++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared cache-to-memory block interface widths and responder state encoding.
package mem_if_pkg;
    localparam int LINE_SIZE  = 32;
    localparam int BLOCK_SIZE = 2;
    localparam int ADDR_SIZE  = 32;
    localparam int BLOCK_W    = (2 ** BLOCK_SIZE) * LINE_SIZE;
    localparam int BA_W       = ADDR_SIZE - BLOCK_SIZE - 2;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        READ_WAIT  = 2'b01,
        WRITE_WAIT = 2'b10,
        DONE       = 2'b11
    } state_e;
endpackage

// File: rtl/block_store.sv
// block_store: block-wide storage array with one sync write port and one registered read port.
module block_store #(
    parameter int BLOCK_W    = mem_if_pkg::BLOCK_W,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    input  logic [DEPTH_LOG2-1:0] idx_i,
    input  logic [BLOCK_W-1:0]    wdata_i,
    output logic [BLOCK_W-1:0]    rdata_o
);
    logic [BLOCK_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [BLOCK_W-1:0] rdata_d, rdata_q;

    // Read data holds its last value until the next read completes.
    always_comb rdata_d = rd_en_i ? mem_q[idx_i] : rdata_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 2**DEPTH_LOG2; i++) mem_q[i] <= '0;
            rdata_q <= '0;
        end else begin
            if (wr_en_i) mem_q[idx_i] <= wdata_i;
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/block_memory_responder.sv
// block_memory_responder: fixed-latency main-memory model serving whole-line refills and write-backs.
module block_memory_responder #(
    parameter int LINE_SIZE      = mem_if_pkg::LINE_SIZE,
    parameter int BLOCK_SIZE     = mem_if_pkg::BLOCK_SIZE,
    parameter int ADDR_SIZE      = mem_if_pkg::ADDR_SIZE,
    parameter int MEM_DEPTH_LOG2 = 8,
    parameter int READ_LATENCY   = 4,
    parameter int WRITE_LATENCY  = 4
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic                                     m_read_i,
    input  logic                                     m_wr_i,
    input  logic [ADDR_SIZE-BLOCK_SIZE-3:0]          m_address_i,
    input  logic [(2**BLOCK_SIZE)*LINE_SIZE-1:0]     m_write_data_i,
    output logic [(2**BLOCK_SIZE)*LINE_SIZE-1:0]     m_read_data_o,
    output logic                                     m_busywait_o,
    output logic                                     m_read_done_o,
    output logic                                     m_write_done_o
);
    import mem_if_pkg::*;

    localparam int BW      = (2 ** BLOCK_SIZE) * LINE_SIZE;
    localparam int AW      = ADDR_SIZE - BLOCK_SIZE - 2;
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_e                    state_d, state_q;
    logic [CNT_W-1:0]          cnt_d, cnt_q;
    logic [MEM_DEPTH_LOG2-1:0] idx_d, idx_q;
    logic [BW-1:0]             wdata_d, wdata_q;
    logic                      busy_d, busy_q;
    logic                      rdone_d, rdone_q;
    logic                      wdone_d, wdone_q;
    logic                      rd_en, wr_en;
    logic                      unused_addr;

    // Upper block-address bits alias onto the stored blocks.
    assign unused_addr = ^m_address_i[AW-1:MEM_DEPTH_LOG2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        rdone_d = rdone_q;
        wdone_d = wdone_q;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_wr_i || m_read_i) begin
                    state_d = m_wr_i ? WRITE_WAIT : READ_WAIT;
                    cnt_d   = m_wr_i ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
                    idx_d   = m_address_i[MEM_DEPTH_LOG2-1:0];
                    wdata_d = m_write_data_i;
                    busy_d  = 1'b1;
                end
            end
            READ_WAIT, WRITE_WAIT: begin
                if (cnt_q == '0) begin
                    rd_en   = (state_q == READ_WAIT);
                    wr_en   = (state_q == WRITE_WAIT);
                    rdone_d = (state_q == READ_WAIT);
                    wdone_d = (state_q == WRITE_WAIT);
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                rdone_d = 1'b0;
                wdone_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            rdone_q <= 1'b0;
            wdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            rdone_q <= rdone_d;
            wdone_q <= wdone_d;
        end
    end

    block_store #(.BLOCK_W(BW), .DEPTH_LOG2(MEM_DEPTH_LOG2)) u_store (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .wr_en_i (wr_en),
        .rd_en_i (rd_en),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (m_read_data_o)
    );

    assign m_busywait_o   = busy_q;
    assign m_read_done_o  = rdone_q;
    assign m_write_done_o = wdone_q;
endmodule
